// File: rtl/dmi_arbiter_if.sv
// rtl/dmi_arbiter_if.sv - requester and DMI target signal bundle for dmi_arbiter
// master drives requests and target responses; slave is the arbiter.
interface dmi_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 7,
   parameter int DATA_WIDTH = 32
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
   logic [NUM_REQ*2-1:0]          req_op;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]         rsp_rdata;
   logic [1:0]                    rsp_resp;

   logic                          dmi_req_valid;
   logic                          dmi_req_ready;
   logic [ADDR_WIDTH-1:0]         dmi_addr;
   logic [DATA_WIDTH-1:0]         dmi_wdata;
   logic [1:0]                    dmi_op;
   logic                          dmi_rsp_valid;
   logic [DATA_WIDTH-1:0]         dmi_rdata;
   logic [1:0]                    dmi_resp;

   logic [IDW-1:0]                grant_id;
   logic                          busy;
   logic                          stray_rsp;

   modport master (
      output req_valid, req_addr, req_wdata, req_op,
      output dmi_req_ready, dmi_rsp_valid, dmi_rdata, dmi_resp,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp,
      input  dmi_req_valid, dmi_addr, dmi_wdata, dmi_op,
      input  grant_id, busy, stray_rsp
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, req_op,
      input  dmi_req_ready, dmi_rsp_valid, dmi_rdata, dmi_resp,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp,
      output dmi_req_valid, dmi_addr, dmi_wdata, dmi_op,
      output grant_id, busy, stray_rsp
   );
endinterface

// File: rtl/dmi_arbiter.sv
// rtl/dmi_arbiter.sv - round-robin arbiter sharing one DMI target port
// One transaction at a time: accept, issue, wait for response, return; a timeout bounds each one.
module dmi_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 7,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          rst,
   dmi_arbiter_if.slave  bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   localparam logic [1:0] OP_NOP    = 2'd0;
   localparam logic [1:0] OP_RSV    = 2'd3;
   localparam logic [1:0] RESP_OK   = 2'd0;
   localparam logic [1:0] RESP_FAIL = 2'd2;
   localparam logic [1:0] RESP_BUSY = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT_RSP = 2'd2,
      S_RESP     = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [IDW-1:0]        owner_q, owner_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [1:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  stray_q, stray_d;

   logic                  win_found;
   logic [IDW-1:0]        win_idx;
   logic [IDW-1:0]        scan_idx;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic [1:0]            win_op;
   logic                  timeout_hit;

   function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
      return (x == IDW'(NUM_REQ - 1)) ? '0 : x + 1'b1;
   endfunction

   // Scan starts at the pointer and walks upward with wrap; first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = ptr_q;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found && bus.req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
         scan_idx = wrap_inc(scan_idx);
      end
   end

   assign win_addr    = bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign win_wdata   = bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
   assign win_op      = bus.req_op[win_idx*2 +: 2];
   assign timeout_hit = TO_EN && (cnt_q >= TO_LAST);

   always_comb begin
      state_d           = state_q;
      ptr_d             = ptr_q;
      owner_d           = owner_q;
      addr_d            = addr_q;
      wdata_d           = wdata_q;
      op_d              = op_q;
      rdata_d           = rdata_q;
      resp_d            = resp_q;
      cnt_d             = cnt_q;
      stray_d           = stray_q | (bus.dmi_rsp_valid && (state_q != S_WAIT_RSP));
      bus.req_ready     = '0;
      bus.rsp_valid     = '0;
      bus.dmi_req_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (win_found) begin
               bus.req_ready = ONE << win_idx;
               owner_d       = win_idx;
               addr_d        = win_addr;
               wdata_d       = win_wdata;
               op_d          = win_op;
               if (win_op == OP_NOP || win_op == OP_RSV) begin
                  rdata_d = '0;
                  resp_d  = (win_op == OP_RSV) ? RESP_FAIL : RESP_OK;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            bus.dmi_req_valid = 1'b1;
            cnt_d             = cnt_q + CW'(1);
            if (bus.dmi_req_ready) begin
               state_d = S_WAIT_RSP;
            end else if (timeout_hit) begin
               rdata_d = '0;
               resp_d  = RESP_BUSY;
               state_d = S_RESP;
            end
         end
         S_WAIT_RSP: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.dmi_rsp_valid) begin
               rdata_d = bus.dmi_rdata;
               resp_d  = bus.dmi_resp;
               state_d = S_RESP;
            end else if (timeout_hit) begin
               rdata_d = '0;
               resp_d  = RESP_BUSY;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            bus.rsp_valid = ONE << owner_q;
            ptr_d         = wrap_inc(owner_q);
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         op_q    <= '0;
         rdata_q <= '0;
         resp_q  <= '0;
         cnt_q   <= '0;
         stray_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         op_q    <= op_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
         cnt_q   <= cnt_d;
         stray_q <= stray_d;
      end
   end

   // grant_id follows a fresh grant in its accept cycle, otherwise holds the last owner.
   assign bus.grant_id  = (state_q == S_IDLE && win_found) ? win_idx : owner_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.stray_rsp = stray_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_resp  = resp_q;
   assign bus.dmi_addr  = addr_q;
   assign bus.dmi_wdata = wdata_q;
   assign bus.dmi_op    = op_q;
endmodule
